adc_sampler_mc: RTL and testbench
=================================

Name: adc_sampler_mc

Overview:
Multi-channel, parametrised ADC sampler that replaces the external slow sample clock with an internal programmable sample-rate divider on the single system clock. It snapshots all channels on each sample tick and optionally averages 2^N snapshots per channel. It serialises the results into a small output FIFO with a valid/ready stream interface. It sits between the ADC controller IP (parallel continuous outputs) and the downstream DSP/filter chain, and it counts dropped frames.

Parameters:
DATA_W, 12, bits per ADC sample
NUM_CH, 2, number of ADC channels (>=1)
DIV_W, 16, width of sample period input
FIFO_DEPTH, 4, output FIFO entries; must be >= NUM_CH and a power of 2
CH_W, max(1,$clog2(NUM_CH)), channel index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
adc_data  in  NUM_CH*DATA_W  continuous ADC controller outputs; ch k = bits [k*DATA_W +: DATA_W]
enable  in  1  run sampler
period  in  DIV_W  sample period in clk cycles; 0 and 1 both mean every cycle
avg_log2  in  2  averaging exponent; 2^avg_log2 snapshots per output
sample_out  out  DATA_W  sample data (FIFO head)
sample_ch  out  CH_W  channel index of sample_out
sample_valid  out  1  FIFO head valid
sample_ready  in  1  downstream accept; transfer = valid & ready
overrun_cnt  out  8  dropped-frame count, saturating at 255

Behaviour:
- Reset (rst=1 at posedge): divider count=0, accumulation count=0, accumulators=0, serializer IDLE, FIFO empty. Outputs: sample_valid=0, sample_out=0, sample_ch=0, overrun_cnt=0. Reset mid-frame discards everything in flight.
- Divider: enable=0 holds count at 0. With enable=1, tick when count >= period-1 (or period<=1), then count<=0; otherwise count++. A period change takes effect on the next compare, so the count never runs away past a reduced period.
- On a tick: acc[k] += adc_data ch k. Accumulator width is DATA_W+3. Accumulation count increments.
- avg_log2 is latched when accumulation count is 0 at a tick (window start). A mid-window change has no effect until the next window.
- Window end: on the tick where accumulation count reaches 2^avg_lat - 1:
  - frame[k] = (acc[k] + adc_data k) >> avg_lat, low DATA_W bits (truncating).
  - Accumulators and accumulation count clear.
  - With avg_log2=0, every tick is a window end and the output is the raw sample.
- Frame acceptance, evaluated in the window-end cycle: accept iff serializer IDLE and (FIFO_DEPTH - fifo_count) >= NUM_CH. fifo_count is the registered value; a same-cycle pop is not credited.
  - Accept: latch frame, serializer goes to EMIT.
  - Reject: frame discarded, overrun_cnt++ (saturating).
- Serializer FSM, states IDLE and EMIT(idx):
  - EMIT pushes {idx, frame[idx]} into the FIFO, one per cycle, idx = 0..NUM_CH-1 in order.
  - After idx = NUM_CH-1 it returns to IDLE.
  - Space is guaranteed by the acceptance rule, so there is no stall.
- FIFO:
  - Registered head. An entry written in cycle C is visible on sample_out/sample_ch with sample_valid=1 no earlier than cycle C+1.
  - Simultaneous push and pop is allowed; count is unchanged.
  - Pop only on valid & ready. sample_out/sample_ch hold stable while valid & !ready.
  - Empty implies sample_valid=0.
- Latency (avg_log2=0, FIFO empty, ready=1): tick in cycle T → ch0 valid in T+2, ch1 in T+3, … ch NUM_CH-1 in T+NUM_CH+1.
- enable falling: divider and accumulators clear immediately. An accepted frame still finishes emitting. The FIFO keeps draining. No overrun is counted while disabled.
- Throughput: sustained lossless operation requires period*2^avg_log2 >= NUM_CH+1 with ready held high.

Test Plan:
- Reset/idle: assert rst 2 cycles, enable=0 → sample_valid=0, overrun_cnt=0, no pushes for 100 cycles.
- Raw 2-ch: period=10, avg_log2=0, ch0=0x123, ch1=0xABC, ready=1 → every 10 cycles exactly 0x123/ch0 then 0xABC/ch1 on consecutive cycles, first valid 2 cycles after tick.
- Averaging: avg_log2=2, ch0 stepped 100,101,102,104 over 4 ticks → single ch0 output 101 ((407)>>2), 1 output per 4 ticks.
- Backpressure/overrun: period=1, ready=0, FIFO_DEPTH=4, NUM_CH=2 → FIFO fills to 4, sample_out stable, overrun_cnt increments each later window end and saturates at 255; release ready → 4 entries in order ch0,ch1,ch0,ch1.
- Period change and enable: switch period 20→3 while count=15 → tick next cycle, then every 3. Drop enable mid-emit → remaining channels still emitted, no new ticks.
- Reset mid-operation: rst during EMIT with FIFO holding 3 entries → next cycle sample_valid=0, overrun_cnt=0, and first post-reset frame correct.

Source files
------------

// File: rtl/adc_sampler_mc.sv
// Multi-channel ADC sampler: internal sample-rate divider, optional 2^N averaging,
// frame serialiser and small output FIFO with a valid/ready stream.
module adc_sampler_mc #(
   parameter int DATA_W     = 12,
   parameter int NUM_CH     = 2,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] adc_data,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         period,
   input  logic [1:0]               avg_log2,
   output logic [DATA_W-1:0]        sample_out,
   output logic [CH_W-1:0]          sample_ch,
   output logic                     sample_valid,
   input  logic                     sample_ready,
   output logic [7:0]               overrun_cnt
);

   localparam int ACC_W = DATA_W + 3;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = CH_W + DATA_W;

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   logic [DIV_W-1:0]  div_cnt_r;
   logic              tick_s;
   logic [2:0]        acc_cnt_r;
   logic [1:0]        avg_lat_r;
   logic [1:0]        avg_eff_s;
   logic [2:0]        win_last_s;
   logic              win_end_s;
   logic [ACC_W-1:0]  acc_r   [NUM_CH];
   logic [ACC_W-1:0]  sum_s   [NUM_CH];
   logic [DATA_W-1:0] frame_s [NUM_CH];
   logic [DATA_W-1:0] frame_r [NUM_CH];
   state_t            state_r, state_nxt;
   logic [CH_W-1:0]   idx_r, idx_nxt;
   logic              room_ok_s;
   logic              accept_s;
   logic              push_s;
   logic [ENT_W-1:0]  push_data_s;
   logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_nxt_s;
   logic [CNT_W-1:0]  fifo_cnt_r, cnt_nxt_s;
   logic              pop_s;
   logic [ENT_W-1:0]  head_s;

   // Sample tick: a reduced period is seen on the very next compare, so >= rather than ==.
   always_comb begin
      tick_s = 1'b0;
      if (!enable) begin
         tick_s = 1'b0;
      end else if (period <= DIV_W'(1)) begin
         tick_s = 1'b1;
      end else if (div_cnt_r >= period - DIV_W'(1)) begin
         tick_s = 1'b1;
      end else begin
         tick_s = 1'b0;
      end
   end

   // Divider counter
   always_ff @(posedge clk) begin
      if (rst || !enable || tick_s) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // Window bookkeeping; the exponent in force is the live input only at window start.
   always_comb begin
      avg_eff_s  = avg_lat_r;
      win_last_s = 3'd0;
      if (acc_cnt_r == 3'd0) begin
         avg_eff_s = avg_log2;
      end else begin
         avg_eff_s = avg_lat_r;
      end
      case (avg_eff_s)
         2'd0:    win_last_s = 3'd0;
         2'd1:    win_last_s = 3'd1;
         2'd2:    win_last_s = 3'd3;
         2'd3:    win_last_s = 3'd7;
         default: win_last_s = 3'd0;
      endcase
      win_end_s = tick_s && (acc_cnt_r == win_last_s);
      for (int k = 0; k < NUM_CH; k++) begin
         sum_s[k]   = acc_r[k] + ACC_W'(adc_data[k*DATA_W +: DATA_W]);
         frame_s[k] = DATA_W'(sum_s[k] >> avg_eff_s);
      end
   end

   // Accumulators
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt_r <= 3'd0;
         avg_lat_r <= 2'd0;
         for (int k = 0; k < NUM_CH; k++) acc_r[k] <= '0;
      end else if (!enable || win_end_s) begin
         acc_cnt_r <= 3'd0;
         for (int k = 0; k < NUM_CH; k++) acc_r[k] <= '0;
      end else if (tick_s) begin
         acc_cnt_r <= acc_cnt_r + 3'd1;
         if (acc_cnt_r == 3'd0) avg_lat_r <= avg_log2;
         for (int k = 0; k < NUM_CH; k++) acc_r[k] <= sum_s[k];
      end
   end

   // Room check uses the registered count; a same-cycle pop earns no credit.
   always_comb begin
      room_ok_s = ((CNT_W'(FIFO_DEPTH) - fifo_cnt_r) >= CNT_W'(NUM_CH));
   end

   // Serialiser next-state and push generation
   always_comb begin
      state_nxt   = state_r;
      idx_nxt     = idx_r;
      accept_s    = 1'b0;
      push_s      = 1'b0;
      push_data_s = '0;
      case (state_r)
         IDLE: begin
            if (win_end_s && room_ok_s) begin
               accept_s  = 1'b1;
               state_nxt = EMIT;
               idx_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         EMIT: begin
            push_s      = 1'b1;
            push_data_s = {idx_r, frame_r[idx_r]};
            if (idx_r == CH_W'(NUM_CH - 1)) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt   = idx_r + CH_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Serialiser state, frame latch and overrun counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= '0;
         overrun_cnt <= 8'd0;
         for (int k = 0; k < NUM_CH; k++) frame_r[k] <= '0;
      end else begin
         state_r <= state_nxt;
         idx_r   <= idx_nxt;
         if (accept_s) begin
            for (int k = 0; k < NUM_CH; k++) frame_r[k] <= frame_s[k];
         end
         if (win_end_s && !accept_s && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end

   // Next head: an entry pushed into an otherwise-empty FIFO bypasses storage.
   always_comb begin
      pop_s     = sample_valid & sample_ready;
      rd_nxt_s  = rd_ptr_r;
      if (pop_s) begin
         rd_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
      cnt_nxt_s = fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      if ((fifo_cnt_r - CNT_W'(pop_s)) == CNT_W'(0)) begin
         head_s = push_data_s;
      end else begin
         head_s = mem_r[rd_nxt_s];
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (!rst && push_s) mem_r[wr_ptr_r] <= push_data_s;
   end

   // FIFO pointers and registered head outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         fifo_cnt_r   <= '0;
         sample_valid <= 1'b0;
         sample_out   <= '0;
         sample_ch    <= '0;
      end else begin
         if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
         rd_ptr_r     <= rd_nxt_s;
         fifo_cnt_r   <= cnt_nxt_s;
         sample_valid <= (cnt_nxt_s != CNT_W'(0));
         if (cnt_nxt_s != CNT_W'(0)) {sample_ch, sample_out} <= head_s;
      end
   end

endmodule

// File: tb/tb_adc_sampler_mc.sv
// Scoreboard bench for adc_sampler_mc: a cycle-level reference model predicts
// frames and FIFO occupancy; a separate monitor compares every transferred beat.
module tb_adc_sampler_mc;
   localparam int DATA_W     = 12;
   localparam int NUM_CH     = 2;
   localparam int DIV_W      = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int CH_W       = 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_CH*DATA_W-1:0] adc_data;
   logic                     enable;
   logic [DIV_W-1:0]         period;
   logic [1:0]               avg_log2;
   logic [DATA_W-1:0]        sample_out;
   logic [CH_W-1:0]          sample_ch;
   logic                     sample_valid;
   logic                     sample_ready;
   logic [7:0]               overrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_acc [NUM_CH];
   int m_acnt, m_lat, m_div, m_emit, m_occ, m_ovr;
   logic [CH_W+DATA_W-1:0] exp_q [$];

   adc_sampler_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W),
                    .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .adc_data(adc_data), .enable(enable),
      .period(period), .avg_log2(avg_log2), .sample_out(sample_out),
      .sample_ch(sample_ch), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .overrun_cnt(overrun_cnt));

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int chv(input int k);
      return int'(adc_data[k*DATA_W +: DATA_W]);
   endfunction

   // Predict what the coming clock edge does, from the inputs as they stand now.
   task automatic model_edge();
      bit tick, push_now, pop_now, accept;
      logic [CH_W+DATA_W-1:0] e;
      if (rst) begin
         foreach (m_acc[k]) m_acc[k] = 0;
         m_acnt = 0; m_lat = 0; m_div = 0; m_emit = 0; m_occ = 0; m_ovr = 0;
         exp_q.delete();
         return;
      end
      push_now = (m_emit > 0);
      pop_now  = (m_occ > 0) && sample_ready;
      tick     = enable && ((int'(period) <= 1) || (m_div >= int'(period) - 1));
      accept   = 0;
      if (!enable) begin
         m_div = 0; m_acnt = 0;
         foreach (m_acc[k]) m_acc[k] = 0;
      end else if (tick) begin
         m_div = 0;
         if (m_acnt == 0) m_lat = int'(avg_log2);
         foreach (m_acc[k]) m_acc[k] += chv(k);
         m_acnt++;
         if (m_acnt == (1 << m_lat)) begin
            if (m_emit == 0 && (FIFO_DEPTH - m_occ) >= NUM_CH) begin
               accept = 1;
               for (int k = 0; k < NUM_CH; k++) begin
                  e = {CH_W'(k), DATA_W'(m_acc[k] / (1 << m_lat))};
                  exp_q.push_back(e);
               end
            end else if (m_ovr < 255) begin
               m_ovr++;
            end
            foreach (m_acc[k]) m_acc[k] = 0;
            m_acnt = 0;
         end
      end else begin
         m_div++;
      end
      m_occ = m_occ + int'(push_now) - int'(pop_now);
      if (push_now) m_emit--;
      if (accept) m_emit = NUM_CH;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("valid", sample_valid, (m_occ != 0));
      check("overrun", overrun_cnt, m_ovr);
   endtask

   task automatic rand_data();
      for (int k = 0; k < NUM_CH; k++) adc_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
   endtask

   // Monitor: compares each transferred beat and holds stalled heads stable.
   initial begin
      logic [CH_W+DATA_W-1:0] held, e;
      bit stalled;
      stalled = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 0;
         end else begin
            if (stalled && sample_valid) check("hold_stable", {sample_ch, sample_out}, held);
            if (sample_valid && sample_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: actual=0x%0h required=none at %0t",
                           {sample_ch, sample_out}, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", {sample_ch, sample_out}, e);
               end
               stalled = 0;
            end else if (sample_valid) begin
               stalled = 1;
               held = {sample_ch, sample_out};
            end else begin
               stalled = 0;
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; enable = 1'b0; sample_ready = 1'b1;
      period = '0; avg_log2 = 2'd0; adc_data = '0;

      // reset and idle
      step(); step();
      check("reset_out", sample_out, 0);
      check("reset_ch", sample_ch, 0);
      rst = 1'b0;
      repeat (100) step();

      // raw two-channel capture
      period = DIV_W'(10);
      adc_data = {DATA_W'(12'hABC), DATA_W'(12'h123)};
      enable = 1'b1;
      repeat (60) step();

      // averaging over four ticks
      enable = 1'b0; step();
      enable = 1'b1; period = DIV_W'(1); avg_log2 = 2'd2;
      adc_data[DATA_W +: DATA_W] = DATA_W'(7);
      adc_data[0 +: DATA_W] = DATA_W'(100); step();
      adc_data[0 +: DATA_W] = DATA_W'(101); step();
      adc_data[0 +: DATA_W] = DATA_W'(102); step();
      adc_data[0 +: DATA_W] = DATA_W'(104); step();
      enable = 1'b0;
      n = 0;
      while (!sample_valid && n < 10) begin step(); n++; end
      check("avg_wait", (n < 10), 1);
      check("avg_ch0_value", sample_out, 101);
      check("avg_ch0_index", sample_ch, 0);
      repeat (10) step();

      // backpressure and overrun saturation
      avg_log2 = 2'd0; period = DIV_W'(1); sample_ready = 1'b0; enable = 1'b1;
      repeat (300) begin rand_data(); step(); end
      check("overrun_saturated", overrun_cnt, 255);
      check("full_valid", sample_valid, 1);
      sample_ready = 1'b1; enable = 1'b0;
      repeat (10) step();
      check("drained_after_release", exp_q.size(), 0);

      // reset mid-emit with three entries queued
      sample_ready = 1'b0; period = DIV_W'(1); enable = 1'b1;
      n = 0;
      while (!(m_occ == 3 && m_emit > 0) && n < 20) begin rand_data(); step(); n++; end
      check("midemit_wait", (n < 20), 1);
      rst = 1'b1; step();
      check("rst_valid", sample_valid, 0);
      check("rst_overrun", overrun_cnt, 0);
      rst = 1'b0; sample_ready = 1'b1;
      adc_data = {DATA_W'(12'h0F0), DATA_W'(12'h5A5)};
      repeat (20) step();

      // period change 20 -> 3 while counting
      enable = 1'b0; step();
      period = DIV_W'(20); enable = 1'b1;
      n = 0;
      while (m_div != 15 && n < 40) begin step(); n++; end
      check("period_wait", (n < 40), 1);
      period = DIV_W'(3);
      repeat (12) begin rand_data(); step(); end

      // drop enable mid-emit
      period = DIV_W'(5);
      n = 0;
      while (m_emit != NUM_CH - 1 && n < 20) begin step(); n++; end
      check("emit_wait", (n < 20), 1);
      enable = 1'b0;
      repeat (20) step();

      // randomised operation
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) begin
            period   = DIV_W'($urandom_range(0, 6));
            avg_log2 = 2'($urandom_range(0, 3));
         end
         enable       = ($urandom_range(0, 9) != 0);
         sample_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         step();
      end

      enable = 1'b0; sample_ready = 1'b1;
      repeat (20) step();
      check("final_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
